// File: rtl/linear_regression_pkg.sv
// Shared widths, default coefficients and coefficient-select encodings
// for the linear price predictor.
package linear_regression_pkg;

    localparam int SIZE_W  = 16;
    localparam int PRICE_W = 32;
    localparam int SUM_W   = PRICE_W + 1;

    localparam logic [SIZE_W-1:0]  DEFAULT_SLOPE     = 16'd3000;
    localparam logic [PRICE_W-1:0] DEFAULT_INTERCEPT = 32'd50000;
    localparam logic [PRICE_W-1:0] PRICE_MAX         = 32'hFFFF_FFFF;

    typedef enum logic {
        COEF_SLOPE     = 1'b0,
        COEF_INTERCEPT = 1'b1
    } coef_sel_e;

    // Unsigned add with clipping to the all-ones price; bit PRICE_W is the carry.
    function automatic logic [SUM_W-1:0] add_sat(input logic [PRICE_W-1:0] a,
                                                  input logic [PRICE_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[PRICE_W]) begin
            return {1'b1, PRICE_MAX};
        end
        return {1'b0, sum[PRICE_W-1:0]};
    endfunction

endpackage

// File: rtl/lr_mac_sat.sv
// Two-stage datapath: registered 16x16 product with its intercept, then a
// saturating 33-bit add into the held price/saturated registers.
module lr_mac_sat
    import linear_regression_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_s1,
    input  logic               load_s2,
    input  logic [SIZE_W-1:0]  size,
    input  logic [SIZE_W-1:0]  slope,
    input  logic [PRICE_W-1:0] intercept,
    output logic [PRICE_W-1:0] price,
    output logic               saturated
);

    logic [PRICE_W-1:0] product_reg;
    logic [PRICE_W-1:0] intercept_s1_reg;
    logic [PRICE_W-1:0] price_reg;
    logic               saturated_reg;
    logic [SUM_W-1:0]   sum_next;

    assign sum_next = add_sat(product_reg, intercept_s1_reg);

    // Stage 1: capture product and the intercept that belongs to this sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            product_reg      <= '0;
            intercept_s1_reg <= '0;
        end else if (load_s1) begin
            product_reg      <= PRICE_W'(slope) * PRICE_W'(size);
            intercept_s1_reg <= intercept;
        end
    end

    // Stage 2: update the result only for valid samples; otherwise hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            price_reg     <= '0;
            saturated_reg <= 1'b0;
        end else if (load_s2) begin
            price_reg     <= sum_next[PRICE_W-1:0];
            saturated_reg <= sum_next[PRICE_W];
        end
    end

    assign price     = price_reg;
    assign saturated = saturated_reg;

endmodule

// File: rtl/linear_regression.sv
// Linear price predictor: price = slope * size + intercept, two-cycle
// latency, one sample per cycle, with runtime-writable coefficients.
module linear_regression
    import linear_regression_pkg::*;
#(
    parameter logic [SIZE_W-1:0]  SLOPE_INIT     = DEFAULT_SLOPE,
    parameter logic [PRICE_W-1:0] INTERCEPT_INIT = DEFAULT_INTERCEPT
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SIZE_W-1:0]  size,
    input  logic               in_valid,
    input  logic               coef_we,
    input  logic               coef_sel,
    input  logic [PRICE_W-1:0] coef_data,
    output logic [PRICE_W-1:0] price,
    output logic               out_valid,
    output logic               saturated
);

    logic [SIZE_W-1:0]  slope_reg;
    logic [PRICE_W-1:0] intercept_reg;
    logic               valid_s1_reg;
    logic               out_valid_reg;

    // Coefficient registers; a sample accepted on the write edge still sees the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            slope_reg     <= SLOPE_INIT;
            intercept_reg <= INTERCEPT_INIT;
        end else if (coef_we) begin
            if (coef_sel == COEF_INTERCEPT) begin
                intercept_reg <= coef_data;
            end else begin
                slope_reg <= coef_data[SIZE_W-1:0];
            end
        end
    end

    // Valid pipeline; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            valid_s1_reg  <= in_valid;
            out_valid_reg <= valid_s1_reg;
        end
    end

    lr_mac_sat u_mac_sat (
        .clk       (clk),
        .rst       (rst),
        .load_s1   (in_valid),
        .load_s2   (valid_s1_reg),
        .size      (size),
        .slope     (slope_reg),
        .intercept (intercept_reg),
        .price     (price),
        .saturated (saturated)
    );

    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_linear_regression.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a transaction-level model of the predictor.
module tb_linear_regression;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] size;
    logic        in_valid;
    logic        coef_we;
    logic        coef_sel;
    logic [31:0] coef_data;
    logic [31:0] price;
    logic        out_valid;
    logic        saturated;

    always #5 clk = ~clk;

    linear_regression dut (
        .clk       (clk),
        .rst       (rst),
        .size      (size),
        .in_valid  (in_valid),
        .coef_we   (coef_we),
        .coef_sel  (coef_sel),
        .coef_data (coef_data),
        .price     (price),
        .out_valid (out_valid),
        .saturated (saturated)
    );

    typedef struct {
        int          due;
        logic [31:0] p;
        logic        s;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    longint unsigned m_slope = 3000;
    longint unsigned m_int   = 50000;
    logic [31:0] m_price = '0;
    logic        m_sat   = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare all outputs.
    task automatic step(input logic r, input logic iv, input logic [15:0] sz,
                        input logic we, input logic sel, input logic [31:0] d);
        logic exp_v;
        ent_t e;
        longint unsigned full;
        rst = r; in_valid = iv; size = sz; coef_we = we; coef_sel = sel; coef_data = d;
        @(posedge clk);
        #1;
        cyc++;
        exp_v = 1'b0;
        if (r) begin
            q.delete();
            m_slope = 3000;
            m_int   = 50000;
            m_price = '0;
            m_sat   = 1'b0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_v   = 1'b1;
                m_price = e.p;
                m_sat   = e.s;
            end
            if (iv) begin
                full = m_slope * longint'(sz) + m_int;
                e.due = cyc + 1;
                if (full > 64'hFFFF_FFFF) begin
                    e.p = 32'hFFFF_FFFF;
                    e.s = 1'b1;
                end else begin
                    e.p = full[31:0];
                    e.s = 1'b0;
                end
                q.push_back(e);
            end
            if (we) begin
                if (sel) m_int = longint'(d);
                else     m_slope = longint'(d[15:0]);
            end
        end
        check_val("out_valid", 64'(out_valid), 64'(exp_v));
        check_val("price", 64'(price), 64'(m_price));
        check_val("saturated", 64'(saturated), 64'(m_sat));
        if (exp_v)
            $display("cyc=%0d out price=%0d sat=%0b", cyc, price, saturated);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic reset_dut();
        step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; size = '0; coef_we = 1'b0; coef_sel = 1'b0; coef_data = '0;
        reset_dut();

        // Default coefficients, back-to-back samples.
        step(0, 1, 16'd32, 0, 0, 0);
        step(0, 1, 16'd100, 0, 0, 0);
        step(0, 1, 16'd50, 0, 0, 0);
        step(0, 1, 16'd0, 0, 0, 0);
        idle(3);

        // Slope 2 (upper bits must be ignored), intercept 10, size 7.
        step(0, 0, 16'd0, 1, 0, 32'hABCD_0002);
        step(0, 0, 16'd0, 1, 1, 32'd10);
        step(0, 1, 16'd7, 0, 0, 0);
        idle(3);

        // Saturation corner and exact all-ones result.
        step(0, 0, 16'd0, 1, 0, 32'h0000_FFFF);
        step(0, 0, 16'd0, 1, 1, 32'hFFFF_FFFF);
        step(0, 1, 16'hFFFF, 0, 0, 0);
        step(0, 1, 16'd0, 0, 0, 0);
        idle(3);

        // Write on the same cycle as a sample: old slope applies.
        reset_dut();
        step(0, 1, 16'd10, 1, 0, 32'd1);
        step(0, 1, 16'd10, 0, 0, 0);
        idle(3);

        // Reset with samples in flight, then confirm defaults restored.
        step(0, 1, 16'd5, 0, 0, 0);
        step(0, 1, 16'd6, 0, 0, 0);
        step(1, 1, 16'd7, 1, 1, 32'd99);
        idle(3);
        step(0, 1, 16'd1, 0, 0, 0);
        idle(2);

        // Gap handling: one sample, then idles with held result.
        step(0, 1, 16'd32, 0, 0, 0);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        r, iv, we, sel;
            logic [15:0] sz;
            logic [31:0] d;
            r   = ($urandom_range(0, 99) < 2);
            iv  = ($urandom_range(0, 99) < 75);
            we  = ($urandom_range(0, 99) < 12);
            sel = $urandom_range(0, 1);
            sz  = 16'($urandom);
            d   = ($urandom_range(0, 3) == 0) ? (32'hF000_0000 | $urandom) : 32'($urandom_range(0, 100000));
            step(r, iv, sz, we, sel, d);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
